// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:2 stream demultiplexer.
package demux_pkg;

  // Values of s_sel naming each output.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Default payload and counter widths.
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNTW  = 16;

  // Occupancy of a one-entry output slice.
  typedef enum logic {
    SLICE_EMPTY = 1'b0,
    SLICE_FULL  = 1'b1
  } slice_state_e;

endpackage

// File: rtl/out_slice.sv
// One-entry output register slice: holds a single beat until the sink takes it,
// and can drain and refill in the same cycle.
module out_slice
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_load,
  input  logic [WIDTH-1:0] in_data,
  output logic             free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  slice_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Slot can take a beat this cycle; reset treats the slot as empty.
  always_comb begin
    free = rst || (state_q == SLICE_EMPTY) || out_ready;
  end

  // Registered outputs only, so out_valid never depends on out_ready.
  always_comb begin
    out_valid = (state_q == SLICE_FULL);
    out_data  = data_q;
  end

  // Next-state: load wins over drain, giving back-to-back throughput.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLICE_EMPTY: begin
        if (in_load) begin
          state_d = SLICE_FULL;
          data_d  = in_data;
        end
      end
      SLICE_FULL: begin
        if (in_load) begin
          data_d = in_data;
        end else if (out_ready) begin
          state_d = SLICE_EMPTY;
        end
      end
      default: state_d = SLICE_EMPTY;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLICE_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// 1:2 stream demultiplexer: routes each input beat to m0 or m1 by s_sel,
// with an independent one-entry slice and delivered-beat counter per output.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sel,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [WIDTH-1:0] m0_data,
  output logic             m1_valid,
  input  logic             m1_ready,
  output logic [WIDTH-1:0] m1_data,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic            free0, free1;
  logic            load0, load1;
  logic            fire0, fire1;
  logic [CNTW-1:0] cnt0_q, cnt0_d;
  logic [CNTW-1:0] cnt1_q, cnt1_d;

  // Input readiness follows the slice addressed by the current beat.
  always_comb begin
    s_ready = (s_sel == PORT1) ? free1 : free0;
  end

  // Steer an accepted beat into exactly one slice; handshakes per output.
  always_comb begin
    load0 = s_valid && s_ready && (s_sel == PORT0) && !rst;
    load1 = s_valid && s_ready && (s_sel == PORT1) && !rst;
    fire0 = m0_valid && m0_ready;
    fire1 = m1_valid && m1_ready;
  end

  out_slice #(.WIDTH(WIDTH)) u_slice0 (
    .clk       (clk),
    .rst       (rst),
    .in_load   (load0),
    .in_data   (s_data),
    .free      (free0),
    .out_valid (m0_valid),
    .out_data  (m0_data),
    .out_ready (m0_ready)
  );

  out_slice #(.WIDTH(WIDTH)) u_slice1 (
    .clk       (clk),
    .rst       (rst),
    .in_load   (load1),
    .in_data   (s_data),
    .free      (free1),
    .out_valid (m1_valid),
    .out_data  (m1_data),
    .out_ready (m1_ready)
  );

  // Counter next-state: wrap silently on overflow.
  always_comb begin
    cnt0_d = fire0 ? cnt0_q + CNTW'(1) : cnt0_q;
    cnt1_d = fire1 ? cnt1_q + CNTW'(1) : cnt1_q;
  end

  // Counter registers; reset wins so no delivery is counted in a reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  // Counter outputs.
  always_comb begin
    cnt0 = cnt0_q;
    cnt1 = cnt1_q;
  end

endmodule
